// File: rtl/tim_cmp.sv
// Compare/alarm stage behind the timer: raises a sticky irq when the timer steps onto
// the programmed compare value, with one-shot/periodic re-arm, overrun flag and hit count.
module tim_cmp #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] tim_i,
    input  logic         cmp_we_i,
    input  logic [W-1:0] cmp_d_i,
    input  logic         arm_i,
    input  logic         disarm_i,
    input  logic         periodic_i,
    input  logic         irq_ack_i,
    output logic         irq_o,
    output logic         ovr_o,
    output logic         armed_o,
    output logic [W-1:0] cmp_o,
    output logic [3:0]   hits_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, PEND = 2'd2} state_e;

    state_e       state_q;
    logic [W-1:0] tim_q;
    logic [W-1:0] cmp_q;
    logic [3:0]   hits_q;
    logic [3:0]   hits_d;
    logic         irq_q;
    logic         ovr_q;
    logic         armed_q;
    logic         adv;
    logic         match;

    // Only a step onto the compare value counts; a held timer or a fresh write never fires.
    assign adv    = (tim_i != tim_q);
    assign match  = adv && (tim_i == cmp_q);
    assign hits_d = (hits_q == 4'hF) ? hits_q : hits_q + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tim_q   <= '0;
            cmp_q   <= '1;
            hits_q  <= 4'd0;
            irq_q   <= 1'b0;
            ovr_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            tim_q <= tim_i;
            if (cmp_we_i) cmp_q <= cmp_d_i;
            case (state_q)
                IDLE: begin
                    if (arm_i && !disarm_i) begin
                        state_q <= ARMED;
                        armed_q <= 1'b1;
                        hits_q  <= 4'd0;
                    end
                end
                ARMED: begin
                    if (disarm_i) begin
                        state_q <= IDLE;
                        armed_q <= 1'b0;
                    end else if (match) begin
                        state_q <= PEND;
                        irq_q   <= 1'b1;
                        hits_q  <= hits_d;
                    end
                end
                PEND: begin
                    if (disarm_i) begin
                        state_q <= IDLE;
                        irq_q   <= 1'b0;
                        armed_q <= 1'b0;
                        ovr_q   <= 1'b0;
                    end else if (irq_ack_i) begin
                        ovr_q <= 1'b0;
                        // Periodic ack racing a new match keeps the interrupt up and counts it.
                        if (periodic_i && match) begin
                            hits_q <= hits_d;
                        end else if (periodic_i) begin
                            state_q <= ARMED;
                            irq_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            irq_q   <= 1'b0;
                            armed_q <= 1'b0;
                        end
                    end else if (match && periodic_i) begin
                        ovr_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                    armed_q <= 1'b0;
                    ovr_q   <= 1'b0;
                end
            endcase
        end
    end

    assign irq_o   = irq_q;
    assign ovr_o   = ovr_q;
    assign armed_o = armed_q;
    assign cmp_o   = cmp_q;
    assign hits_o  = hits_q;

endmodule

// File: tb/tb_tim_cmp.sv
// Scoreboard bench for tim_cmp: a reference model queues expected outputs per driven
// cycle; they are popped and compared one step after the clock edge.
module tb_tim_cmp;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] tim = 4'd0;
    logic       cmp_we = 1'b0;
    logic [3:0] cmp_d = 4'd0;
    logic       arm = 1'b0, disarm = 1'b0, periodic = 1'b0, irq_ack = 1'b0;
    logic       irq, ovr, armed;
    logic [3:0] cmp, hits;

    typedef struct {
        bit       irq;
        bit       ovr;
        bit       armed;
        bit [3:0] cmp;
        bit [3:0] hits;
    } exp_t;

    exp_t sb_q[$];
    int   nchk = 0;
    int   nerr = 0;

    // reference model state: 0 idle, 1 armed, 2 pending
    int       m_st;
    bit [3:0] m_timq, m_cmp, m_hits;
    bit       m_ovr;

    tim_cmp #(.W(4)) dut (
        .clk(clk), .rst(rst), .tim_i(tim), .cmp_we_i(cmp_we), .cmp_d_i(cmp_d),
        .arm_i(arm), .disarm_i(disarm), .periodic_i(periodic), .irq_ack_i(irq_ack),
        .irq_o(irq), .ovr_o(ovr), .armed_o(armed), .cmp_o(cmp), .hits_o(hits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_timq = 4'd0; m_cmp = 4'hF; m_hits = 4'd0; m_ovr = 1'b0;
    endtask

    function automatic bit [3:0] sat_inc(input bit [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    task automatic model_step();
        bit   hit;
        exp_t e;
        hit = (tim != m_timq) && (tim == m_cmp);
        if (m_st == 0) begin
            if (arm && !disarm) begin m_st = 1; m_hits = 4'd0; end
        end else if (m_st == 1) begin
            if (disarm) m_st = 0;
            else if (hit) begin m_st = 2; m_hits = sat_inc(m_hits); end
        end else begin
            if (disarm) begin m_st = 0; m_ovr = 1'b0; end
            else if (irq_ack) begin
                m_ovr = 1'b0;
                if (!periodic) m_st = 0;
                else if (hit) m_hits = sat_inc(m_hits);
                else m_st = 1;
            end else if (hit && periodic) m_ovr = 1'b1;
        end
        m_timq = tim;
        if (cmp_we) m_cmp = cmp_d;
        e.irq = (m_st == 2); e.ovr = m_ovr; e.armed = (m_st != 0);
        e.cmp = m_cmp; e.hits = m_hits;
        sb_q.push_back(e);
    endtask

    // One clock: model the driven inputs, clock the DUT, compare, drop one-cycle pulses.
    task automatic cyc();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk("irq", irq, e.irq);
            chk("ovr", ovr, e.ovr);
            chk("armed", armed, e.armed);
            chk("cmp", cmp, e.cmp);
            chk("hits", hits, e.hits);
        end
        arm = 1'b0; disarm = 1'b0; irq_ack = 1'b0; cmp_we = 1'b0;
    endtask

    task automatic step_to(input bit [3:0] target);
        for (int i = 0; i < 16; i++) begin
            tim = tim + 4'd1;
            cyc();
            if (tim == target) break;
        end
    endtask

    task automatic write_cmp(input bit [3:0] v);
        cmp_d = v; cmp_we = 1'b1; cyc();
    endtask

    initial begin
        model_reset();
        #23;
        chk("rst_irq", irq, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_armed", armed, 0);
        chk("rst_hits", hits, 0);
        chk("rst_cmp", cmp, 15);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // unarmed sweep through every value including the wrap
        for (int t = 1; t <= 16; t++) begin
            tim = t[3:0];
            cyc();
            chk("idle_irq", irq, 0);
        end

        // one-shot at 5
        write_cmp(4'd5);
        chk("cmp_rb", cmp, 5);
        periodic = 1'b0; arm = 1'b1; cyc();
        tim = 4'd3; cyc(); tim = 4'd4; cyc();
        tim = 4'd5; cyc();
        chk("os_irq", irq, 1);
        chk("os_hits", hits, 1);
        step_to(4'd5);
        chk("os_no_ovr", ovr, 0);
        irq_ack = 1'b1; cyc();
        chk("os_ack_irq", irq, 0);
        chk("os_ack_armed", armed, 0);

        // periodic at 2 with overrun
        write_cmp(4'd2);
        periodic = 1'b1; arm = 1'b1; cyc();
        step_to(4'd2);
        chk("per_irq", irq, 1);
        step_to(4'd2);
        chk("per_ovr", ovr, 1);
        chk("per_hits", hits, 1);
        irq_ack = 1'b1; cyc();
        chk("per_ack_irq", irq, 0);
        chk("per_ack_ovr", ovr, 0);
        chk("per_ack_armed", armed, 1);
        step_to(4'd2);
        chk("per_hits2", hits, 2);

        // hold at 7, then compare 0 fires on wrap
        disarm = 1'b1; cyc();
        write_cmp(4'd7);
        arm = 1'b1; cyc();
        step_to(4'd7);
        repeat (10) cyc();
        chk("hold_hits", hits, 1);
        irq_ack = 1'b1; cyc();
        write_cmp(4'd0);
        step_to(4'd15);
        chk("wrap_pre_irq", irq, 0);
        tim = 4'd0; cyc();
        chk("wrap_irq", irq, 1);
        chk("wrap_hits", hits, 2);

        // overrun, then ack coinciding with a match
        step_to(4'd0);
        chk("sim_ovr", ovr, 1);
        step_to(4'd15);
        tim = 4'd0; irq_ack = 1'b1; cyc();
        chk("sim_irq", irq, 1);
        chk("sim_ovr0", ovr, 0);
        chk("sim_hits", hits, 3);
        disarm = 1'b1; irq_ack = 1'b1; cyc();
        chk("dis_irq", irq, 0);
        chk("dis_armed", armed, 0);

        // build PEND with ovr=1 and hits=3, then reset between edges
        arm = 1'b1; cyc();
        step_to(4'd0);
        step_to(4'd15); tim = 4'd0; irq_ack = 1'b1; cyc();
        step_to(4'd15); tim = 4'd0; irq_ack = 1'b1; cyc();
        step_to(4'd0);
        chk("pre_rst_hits", hits, 3);
        chk("pre_rst_ovr", ovr, 1);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_irq", irq, 0);
        chk("mid_rst_ovr", ovr, 0);
        chk("mid_rst_armed", armed, 0);
        chk("mid_rst_hits", hits, 0);
        chk("mid_rst_cmp", cmp, 15);
        model_reset();
        tim = 4'd0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        cyc();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1);
    end

endmodule

// File: doc/tim_cmp.md
# tim_cmp

Compare/alarm stage fed by the 4-bit timer output. It watches the timer value and raises a sticky interrupt when the value advances onto a programmed compare value. The alarm runs in one-shot or periodic mode, flags overruns, and keeps a saturating hit count. It sits directly downstream of the timer block and drives the interrupt line toward the controller.

## Interface
- W, default 4: width of the timer value and the compare register.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- tim  in  W  current timer value from the timer stage; changes only on clk edges.
- cmp_we  in  1  compare write strobe, one cycle.
- cmp_d  in  W  compare value, loaded when cmp_we=1.
- arm  in  1  arm request, one-cycle pulse.
- disarm  in  1  disarm request, one-cycle pulse.
- periodic  in  1  mode, sampled when an irq is acknowledged: 1 re-arms, 0 is one-shot.
- irq_ack  in  1  interrupt acknowledge, one-cycle pulse.
- irq  out  1  interrupt, level, sticky until acknowledged or disarmed.
- ovr  out  1  overrun: a match occurred while irq was already pending in periodic mode.
- armed  out  1  high in states ARMED and PEND.
- cmp  out  W  compare register readback.
- hits  out  4  saturating count of accepted matches.

## Operation
- tim_q is a W-bit register sampling tim every cycle.
- adv = (tim != tim_q).
- match = adv & (tim == cmp), where cmp is the current register value (before any same-cycle write).
- A match fires only on the cycle the timer steps onto the value. A timer that holds at the compare value never re-fires.
- Compare register:
  - cmp_we=1 loads cmp_d at the next edge, in any state.
  - A write never generates a match by itself.
- State machine (IDLE, ARMED, PEND). Request priority is disarm > irq_ack > match > arm.
  - IDLE:
    - arm goes to ARMED and clears hits to 0.
    - match is ignored.
  - ARMED:
    - disarm goes to IDLE.
    - match goes to PEND, sets irq, and increments hits (saturates at 15).
    - arm is ignored.
  - PEND:
    - disarm goes to IDLE and clears irq and ovr.
    - irq_ack without match goes to ARMED if periodic=1, else IDLE; irq and ovr are cleared.
    - irq_ack with match when periodic=1 stays in PEND, keeps irq=1, clears ovr, and increments hits.
    - irq_ack with match when periodic=0 goes to IDLE and the match is dropped.
    - match without ack when periodic=1 sets ovr (sticky); hits is not incremented.
    - match without ack when periodic=0 is ignored.
- Output derivation:
  - armed = (state != IDLE).
  - irq = (state == PEND).
- Arithmetic and wrap-around:
  - tim wrapping from 2^W-1 to 0 counts as an advance.
  - cmp=0 therefore matches on the wrap.
  - All comparisons are unsigned, at width W.

## Timing
- Reset values:
  - state IDLE, irq 0, ovr 0, armed 0, hits 0.
  - cmp all-ones (4'hF), tim_q 0.
- Reset is asynchronous and may assert mid-operation. It forces all reset values immediately; a pending irq is lost.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Match latency: tim takes the compare value at edge k, and irq, hits and ovr update at edge k+1.
- arm, disarm and irq_ack take effect at the next edge. armed and irq reflect the new state one cycle after the pulse.
- cmp readback updates one cycle after cmp_we.
- Multi-cycle pulses on arm, disarm or irq_ack are allowed. They are re-evaluated every cycle under the same priority, with no edge detection.

## Test plan
- Reset, then check idle behaviour:
  - Stimulus: release rst, no other inputs.
  - Required: irq=0, ovr=0, armed=0, hits=0, cmp=4'hF.
  - Then: tim steps 0..15 with the block unarmed; irq must stay 0.
- One-shot:
  - Stimulus: write cmp=5, arm, periodic=0, step tim 3→4→5.
  - Required: irq=1 one cycle after tim=5, hits=1.
  - Then: a second pass through 5 does not set ovr. irq_ack gives irq=0 and armed=0.
- Periodic with overrun:
  - Stimulus: cmp=2, periodic=1, arm; tim passes 2, no ack; tim wraps and passes 2 again.
  - Required: ovr=1 and hits=1.
  - Then: irq_ack clears irq and ovr, with armed still 1. The next pass through 2 gives hits=2.
- Hold and wrap:
  - Stimulus: tim holds at cmp=7 for 10 cycles.
  - Required: exactly one match, hits=1.
  - Then: with cmp=0, tim 15→0 fires irq.
- Simultaneous events:
  - Stimulus: in PEND with periodic=1, irq_ack coincides with a match.
  - Required: irq stays 1, ovr=0, hits increments.
  - Then: disarm asserted together with irq_ack gives IDLE and irq=0.
- Mid-operation reset:
  - Stimulus: assert rst while in PEND with ovr=1 and hits=3.
  - Required: all outputs return to reset values immediately, without waiting for a clock edge.
